mac_seq_ctrl: RTL and testbench

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_pkg.sv | 17 +
 rtl/mac.sv | 34 +++
 rtl/mac_seq_ctrl.sv | 102 ++++++++++
 tb/tb_mac_seq_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared types and default widths for the MAC sequencer.
//   state_e     - sequencer FSM states
//   MAC_DW_DEF  - default operand/accumulator width
//   MAC_LW_DEF  - default element-count width
package mac_pkg;

  localparam int MAC_DW_DEF = 4;
  localparam int MAC_LW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mac.sv
// mac: multiply-accumulate datapath, all arithmetic modulo 2^DW.
//   clk   in   clock
//   clear in   zero the accumulator (wins over load)
//   load  in   add a*b into the accumulator
//   a, b  in   DW-bit operands
//   acc   out  DW-bit accumulator
// There is no reset port. The owner resets the accumulator through clear.
module mac
  import mac_pkg::*;
#(
  parameter int DW = MAC_DW_DEF
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          load,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] acc
);

  logic [DW-1:0] acc_q;
  logic [DW-1:0] prod;

  // The product is truncated to DW bits. Overflow wraps with no flag.
  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (clear)     acc_q <= '0;
    else if (load) acc_q <= acc_q + prod;
  end

  assign acc = acc_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one dot product of len operand pairs through mac.
//   sys_clock, sys_rst_n    clock, synchronous active-low reset
//   start, len              job request (sampled in IDLE only), element count
//   abort                   drop the current job, no result
//   in_valid/in_ready       operand-pair handshake, in_a/in_b operands
//   result/result_valid     dot product mod 2^DW, held until result_ready
//   busy                    high outside IDLE
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int DW = MAC_DW_DEF,
  parameter int LW = MAC_LW_DEF
) (
  input  logic          sys_clock,
  input  logic          sys_rst_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic          in_ready,
  output logic [DW-1:0] result,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] tgt_q, tgt_d;
  logic [LW-1:0] cnt_inc;
  logic          xfer;
  logic          mac_clear;

  assign in_ready     = (state_q == ACCUM);
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);

  // An abort in the same cycle discards the pair, so it never reaches the accumulator.
  assign xfer    = in_valid && in_ready && !abort;
  assign cnt_inc = cnt_q + LW'(1);

  always_ff @(posedge sys_clock) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        // An abort arriving with start is ignored. Start wins.
        if (start) begin
          tgt_d   = len;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (abort)              state_d = IDLE;
        else if (tgt_q == '0)   state_d = DONE;
        else                    state_d = ACCUM;
      end
      ACCUM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (xfer) begin
          // cnt stops at tgt_q, which is at most 2^LW-1, so it cannot wrap.
          cnt_d = cnt_inc;
          if (cnt_inc == tgt_q) state_d = DONE;
        end
      end
      DONE: begin
        if (abort || result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset also clears the accumulator, so an operand presented during reset is never accumulated.
  assign mac_clear = (state_q == CLEAR) || !sys_rst_n;

  mac #(.DW(DW)) u_mac (
    .clk   (sys_clock),
    .clear (mac_clear),
    .load  (xfer),
    .a     (xfer ? in_a : '0),
    .b     (xfer ? in_b : '0),
    .acc   (result)
  );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed self-checking bench for mac_seq_ctrl (DW=4, LW=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mac_seq_ctrl;

  logic       sys_clock = 1'b0;
  logic       sys_rst_n;
  logic       start, abort, in_valid, result_ready;
  logic [3:0] len, in_a, in_b;
  logic       in_ready, result_valid, busy;
  logic [3:0] result;

  int checks = 0;
  int errors = 0;

  always #5 sys_clock = ~sys_clock;

  mac_seq_ctrl #(.DW(4), .LW(4)) dut (
    .sys_clock    (sys_clock),
    .sys_rst_n    (sys_rst_n),
    .start        (start),
    .len          (len),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_ready     (in_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic go(input int n);
    start = 1'b1;
    len   = 4'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic pair(input int a, input int b);
    in_valid = 1'b1;
    in_a     = 4'(a);
    in_b     = 4'(b);
    tick();
    in_valid = 1'b0;
    in_a     = 4'd0;
    in_b     = 4'd0;
  endtask

  initial begin
    sys_rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    result_ready = 1'b0; len = '0; in_a = '0; in_b = '0;
    tick(); tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_rv", int'(result_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    sys_rst_n = 1'b1;
    tick();

    // Basic dot product: 2*3 + 1*4 + 5*1 = 15
    go(3);
    chk("basic_clear_busy", int'(busy), 1);
    chk("basic_clear_rdy", int'(in_ready), 0);
    tick();
    chk("basic_accum_rdy", int'(in_ready), 1);
    pair(2, 3); pair(1, 4); pair(5, 1);
    chk("basic_rv", int'(result_valid), 1);
    chk("basic_result", int'(result), 15);
    chk("basic_rdy_off", int'(in_ready), 0);
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    chk("basic_idle", int'(busy), 0);
    chk("basic_rv_off", int'(result_valid), 0);

    // Wrap: 225 mod 16 = 1, plus 15 gives 16 mod 16 = 0
    go(2); tick();
    pair(15, 15); pair(3, 5);
    chk("wrap_rv", int'(result_valid), 1);
    chk("wrap_result", int'(result), 0);
    result_ready = 1'b1; tick(); result_ready = 1'b0;

    // Bubbles and back-pressure: 4 + 9 = 13
    go(2); tick();
    pair(2, 2);
    in_a = 4'd7; in_b = 4'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bub_rdy", int'(in_ready), 1);
      chk("bub_hold", int'(result), 4);
    end
    pair(3, 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rv", int'(result_valid), 1);
      chk("bp_result", int'(result), 13);
      tick();
    end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    chk("bp_idle", int'(busy), 0);

    // len=0: result_valid two cycles after start, result 0, in_ready never high
    go(0);
    chk("len0_rv_early", int'(result_valid), 0);
    chk("len0_rdy_a", int'(in_ready), 0);
    tick();
    chk("len0_rv", int'(result_valid), 1);
    chk("len0_result", int'(result), 0);
    chk("len0_rdy_b", int'(in_ready), 0);
    result_ready = 1'b1; tick(); result_ready = 1'b0;

    // Abort after two transfers, then a new len=1 job gives 9
    go(4); tick();
    pair(2, 2); pair(2, 2);
    abort = 1'b1; in_valid = 1'b1; in_a = 4'd1; in_b = 4'd1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_idle", int'(busy), 0);
    chk("abort_rv", int'(result_valid), 0);
    go(1); tick(); pair(3, 3);
    chk("abort_new_result", int'(result), 9);
    chk("abort_new_rv", int'(result_valid), 1);
    result_ready = 1'b1; tick(); result_ready = 1'b0;

    // Reset mid-job, with an operand presented during reset
    go(4); tick();
    pair(2, 2); pair(2, 2);
    sys_rst_n = 1'b0; in_valid = 1'b1; in_a = 4'd3; in_b = 4'd3;
    tick();
    sys_rst_n = 1'b1; in_valid = 1'b0;
    chk("rstjob_idle", int'(busy), 0);
    chk("rstjob_result", int'(result), 0);
    go(1); tick(); pair(3, 3);
    chk("rstjob_new_result", int'(result), 9);
    result_ready = 1'b1; tick(); result_ready = 1'b0;

    // Start with len=7 during ACCUM is ignored: 1*2 + 2*2 = 6 after 2 transfers
    go(2); tick();
    start = 1'b1; len = 4'd7;
    pair(1, 2);
    start = 1'b0;
    pair(2, 2);
    chk("ign_rv", int'(result_valid), 1);
    chk("ign_result", int'(result), 6);
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    chk("ign_idle", int'(busy), 0);

    // Abort in IDLE with start: start wins
    abort = 1'b1; go(1); abort = 1'b0;
    chk("abst_busy", int'(busy), 1);
    tick();
    chk("abst_rdy", int'(in_ready), 1);
    pair(3, 3);
    chk("abst_result", int'(result), 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
